// File: rtl/cascade_counter_if.sv
// Control and status bundle of one cascade_counter instance: step/load/clear
// requests in, packed digits and the carry/wrap flags out.
interface cascade_counter_if #(
  parameter int DIGITS = 4,
  parameter int BASE   = 10
);
  localparam int DW = ($clog2(BASE) < 1) ? 1 : $clog2(BASE);

  logic                 clear;
  logic                 load;
  logic [DIGITS*DW-1:0] load_value;
  logic                 enable;
  logic                 up;
  logic [DIGITS*DW-1:0] count;
  logic                 carry_out;
  logic                 wrap;
  logic                 sticky_wrap;

  modport master (
    output clear, load, load_value, enable, up,
    input  count, carry_out, wrap, sticky_wrap
  );

  modport slave (
    input  clear, load, load_value, enable, up,
    output count, carry_out, wrap, sticky_wrap
  );
endinterface

// File: rtl/cascade_counter.sv
// Multi-digit up/down modulo counter: DIGITS digits of radix BASE, with load,
// clear, a combinational chaining carry and registered wrap/sticky-wrap flags.
module cascade_counter #(
  parameter int DIGITS = 4,
  parameter int BASE   = 10
) (
  input  logic            clk,
  input  logic            reset,
  cascade_counter_if.slave bus
);
  localparam int DW = ($clog2(BASE) < 1) ? 1 : $clog2(BASE);
  localparam logic [DW-1:0] MAXD = DW'(BASE - 1);

  logic [DW-1:0] r_digit [DIGITS];
  logic          r_wrap;
  logic          r_sticky;

  logic [DW-1:0] w_clamp [DIGITS];
  logic [DW-1:0] w_next  [DIGITS];
  // Bit i is set when every digit below i is at max (up) / at zero (down).
  logic [DIGITS:0] w_all_max;
  logic [DIGITS:0] w_all_zero;
  logic            w_terminal;
  logic            w_step;

  always_comb begin
    w_all_max  = '0;
    w_all_zero = '0;
    w_all_max[0]  = 1'b1;
    w_all_zero[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      w_all_max[i+1]  = w_all_max[i]  & (r_digit[i] == MAXD);
      w_all_zero[i+1] = w_all_zero[i] & (r_digit[i] == '0);
    end
  end

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      w_next[i]  = r_digit[i];
      w_clamp[i] = bus.load_value[i*DW +: DW];
      if (w_clamp[i] > MAXD) w_clamp[i] = MAXD;
      // Explicit compare against BASE-1 so power-of-two radices wrap the same way.
      if (bus.up) begin
        if (w_all_max[i])
          w_next[i] = (r_digit[i] == MAXD) ? '0 : r_digit[i] + DW'(1);
      end else begin
        if (w_all_zero[i])
          w_next[i] = (r_digit[i] == '0) ? MAXD : r_digit[i] - DW'(1);
      end
    end
  end

  assign w_terminal    = bus.up ? w_all_max[DIGITS] : w_all_zero[DIGITS];
  assign w_step        = bus.enable & ~bus.clear & ~bus.load;
  assign bus.carry_out = w_step & w_terminal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DIGITS; i++) r_digit[i] <= '0;
      r_wrap   <= 1'b0;
      r_sticky <= 1'b0;
    end else if (bus.clear) begin
      for (int i = 0; i < DIGITS; i++) r_digit[i] <= '0;
      r_wrap   <= 1'b0;
      r_sticky <= 1'b0;
    end else if (bus.load) begin
      for (int i = 0; i < DIGITS; i++) r_digit[i] <= w_clamp[i];
      r_wrap <= 1'b0;
    end else if (bus.enable) begin
      for (int i = 0; i < DIGITS; i++) r_digit[i] <= w_next[i];
      r_wrap <= w_terminal;
      if (w_terminal) r_sticky <= 1'b1;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_pack
      assign bus.count[g*DW +: DW] = r_digit[g];
    end
  endgenerate

  assign bus.wrap        = r_wrap;
  assign bus.sticky_wrap = r_sticky;
endmodule

// File: tb/tb_cascade_counter.sv
// Directed bench: a BCD two-digit counter driven from a vector table, plus
// sequences for full-range counting, async reset, base-16 and base-60 chaining.
module tb_cascade_counter;
  logic clk;
  logic rst;

  int n_tests;
  int n_fail;

  cascade_counter_if #(.DIGITS(2), .BASE(10)) bus_a ();
  cascade_counter_if #(.DIGITS(1), .BASE(16)) bus_b ();
  cascade_counter_if #(.DIGITS(1), .BASE(60)) bus_lo ();
  cascade_counter_if #(.DIGITS(1), .BASE(60)) bus_hi ();

  cascade_counter #(.DIGITS(2), .BASE(10)) dut_a  (.clk(clk), .reset(rst), .bus(bus_a.slave));
  cascade_counter #(.DIGITS(1), .BASE(16)) dut_b  (.clk(clk), .reset(rst), .bus(bus_b.slave));
  cascade_counter #(.DIGITS(1), .BASE(60)) dut_lo (.clk(clk), .reset(rst), .bus(bus_lo.slave));
  cascade_counter #(.DIGITS(1), .BASE(60)) dut_hi (.clk(clk), .reset(rst), .bus(bus_hi.slave));

  assign bus_hi.enable = bus_lo.carry_out;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       ld;
    logic [7:0] lv;
    logic       en;
    logic       up;
    logic       exp_carry;
    logic [7:0] exp_count;
    logic       exp_wrap;
    logic       exp_sticky;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  task automatic drive_a(input logic clr, input logic ld, input logic [7:0] lv,
                         input logic en, input logic up);
    @(negedge clk);
    bus_a.clear      = clr;
    bus_a.load       = ld;
    bus_a.load_value = lv;
    bus_a.enable     = en;
    bus_a.up         = up;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    vecs[0]  = '{1'b0, 1'b1, 8'h4F, 1'b0, 1'b1, 1'b0, 8'h49, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'h12, 1'b1, 1'b1, 1'b0, 8'h12, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'h19, 1'b0, 1'b1, 1'b0, 8'h19, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h20, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h19, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h19, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 8'h99, 1'b0, 1'b1, 1'b0, 8'h99, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h99, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h98, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 8'h9A, 1'b0, 1'b1, 1'b0, 8'h99, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 8'hF5, 1'b0, 1'b1, 1'b0, 8'h95, 1'b0, 1'b0};

    bus_a.clear = 1'b0;  bus_a.load = 1'b0;  bus_a.load_value = '0;
    bus_a.enable = 1'b0; bus_a.up = 1'b1;
    bus_b.clear = 1'b0;  bus_b.load = 1'b0;  bus_b.load_value = '0;
    bus_b.enable = 1'b0; bus_b.up = 1'b1;
    bus_lo.clear = 1'b0; bus_lo.load = 1'b0; bus_lo.load_value = '0;
    bus_lo.enable = 1'b0; bus_lo.up = 1'b1;
    bus_hi.clear = 1'b0; bus_hi.load = 1'b0; bus_hi.load_value = '0;
    bus_hi.up = 1'b1;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_count",  32'(bus_a.count), 32'h0);
    check("reset_wrap",   32'(bus_a.wrap), 32'h0);
    check("reset_sticky", 32'(bus_a.sticky_wrap), 32'h0);

    // vector table
    for (int v = 0; v < 17; v++) begin
      drive_a(vecs[v].clr, vecs[v].ld, vecs[v].lv, vecs[v].en, vecs[v].up);
      #1;
      check($sformatf("vec%0d_carry", v), 32'(bus_a.carry_out), 32'(vecs[v].exp_carry));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_count", v),  32'(bus_a.count), 32'(vecs[v].exp_count));
      check($sformatf("vec%0d_wrap", v),   32'(bus_a.wrap), 32'(vecs[v].exp_wrap));
      check($sformatf("vec%0d_sticky", v), 32'(bus_a.sticky_wrap), 32'(vecs[v].exp_sticky));
    end

    // full range 00..99 and wrap
    drive_a(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    @(posedge clk);
    for (int n = 0; n < 100; n++) begin
      drive_a(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      #1;
      check($sformatf("up%0d_carry", n), 32'(bus_a.carry_out), (n == 99) ? 32'h1 : 32'h0);
      @(posedge clk);
      #1;
      check($sformatf("up%0d_count", n), 32'(bus_a.count), 32'(bcd((n + 1) % 100)));
      check($sformatf("up%0d_wrap", n),  32'(bus_a.wrap), (n == 99) ? 32'h1 : 32'h0);
    end
    check("up_sticky", 32'(bus_a.sticky_wrap), 32'h1);

    for (int n = 0; n < 10; n++) begin
      drive_a(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      check($sformatf("hold%0d_count", n), 32'(bus_a.count), 32'h0);
      check($sformatf("hold%0d_wrap", n),  32'(bus_a.wrap), 32'h0);
    end

    // async reset between edges
    drive_a(1'b0, 1'b1, 8'h57, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("pre_rst_count",  32'(bus_a.count), 32'h57);
    check("pre_rst_sticky", 32'(bus_a.sticky_wrap), 32'h1);
    drive_a(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_count",  32'(bus_a.count), 32'h0);
    check("async_rst_wrap",   32'(bus_a.wrap), 32'h0);
    check("async_rst_sticky", 32'(bus_a.sticky_wrap), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive_a(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("post_rst_count", 32'(bus_a.count), 32'h01);
    drive_a(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // base 16 single digit
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      bus_b.enable = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("b16_%0d_count", n), 32'(bus_b.count), 32'(n % 16));
      check($sformatf("b16_%0d_wrap", n),  32'(bus_b.wrap), (n == 16) ? 32'h1 : 32'h0);
    end
    check("b16_sticky", 32'(bus_b.sticky_wrap), 32'h1);
    @(negedge clk);
    bus_b.enable = 1'b0;

    // chained base 60: 03:58 -> 03:59 -> 04:00
    @(negedge clk);
    bus_lo.load = 1'b1; bus_lo.load_value = 6'd58;
    bus_hi.load = 1'b1; bus_hi.load_value = 6'd3;
    @(posedge clk);
    #1;
    check("chain_ld_lo", 32'(bus_lo.count), 32'd58);
    check("chain_ld_hi", 32'(bus_hi.count), 32'd3);
    @(negedge clk);
    bus_lo.load = 1'b0; bus_hi.load = 1'b0;
    bus_lo.enable = 1'b1;
    #1;
    check("chain_s1_en_hi", 32'(bus_hi.enable), 32'h0);
    @(posedge clk);
    #1;
    check("chain_s1_lo", 32'(bus_lo.count), 32'd59);
    check("chain_s1_hi", 32'(bus_hi.count), 32'd3);
    check("chain_s2_en_hi", 32'(bus_hi.enable), 32'h1);
    @(posedge clk);
    #1;
    check("chain_s2_lo", 32'(bus_lo.count), 32'd0);
    check("chain_s2_hi", 32'(bus_hi.count), 32'd4);
    check("chain_s2_lo_wrap", 32'(bus_lo.wrap), 32'h1);
    check("chain_s2_hi_wrap", 32'(bus_hi.wrap), 32'h0);

    // chained 59:59 -> 00:00
    @(negedge clk);
    bus_lo.enable = 1'b0;
    bus_lo.load = 1'b1; bus_lo.load_value = 6'd59;
    bus_hi.load = 1'b1; bus_hi.load_value = 6'd59;
    @(posedge clk);
    @(negedge clk);
    bus_lo.load = 1'b0; bus_hi.load = 1'b0;
    bus_lo.enable = 1'b1;
    #1;
    check("chain_top_carry_hi", 32'(bus_hi.carry_out), 32'h1);
    @(posedge clk);
    #1;
    check("chain_top_lo", 32'(bus_lo.count), 32'd0);
    check("chain_top_hi", 32'(bus_hi.count), 32'd0);
    check("chain_top_hi_wrap", 32'(bus_hi.wrap), 32'h1);
    check("chain_top_hi_sticky", 32'(bus_hi.sticky_wrap), 32'h1);
    @(negedge clk);
    bus_lo.enable = 1'b0;
    @(posedge clk);
    #1;
    check("chain_idle_hi_wrap", 32'(bus_hi.wrap), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
